// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - single-port 32-bit data memory with byte/half/word access and 1-cycle reads
// Optional power-up zeroing engine built when DMEM_INIT_CLEAR_EN is defined.
module data_mem_ctrl #(
   parameter int          ADDR_W    = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mRead,
   input  logic        mWrite,
   input  logic [1:0]  m_size,
   input  logic        m_unsigned,
   input  logic [31:0] addr_in,
   input  logic [31:0] write_data,
   output logic        m_ready,
   output logic        m_rvalid,
   output logic [31:0] m_rdata,
   output logic        m_err
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {CLEAR, RUN} state_t;

`ifdef DMEM_INIT_CLEAR_EN
   localparam state_t RST_STATE = CLEAR;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
`else
   localparam state_t RST_STATE = RUN;
`endif

   state_t            state_q, state_d;
   logic              ready_q, rvalid_q, err_q;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       mem [DEPTH];

   logic [31:0]       offset;
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        lane;
   logic              accept, bad, rd_ok;
   logic [31:0]       rd_shift;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_idx;
   logic [3:0]        wr_be;
   logic [31:0]       wr_data;

   assign offset   = addr_in - BASE_ADDR;
   assign word_idx = offset[ADDR_W+1:2];
   assign lane     = offset[1:0];
   assign accept   = ready_q & (mRead | mWrite);
   assign rd_ok    = accept & mRead & ~bad;

   always_comb begin
      bad = 1'b0;
      if (mRead && mWrite) bad = 1'b1;
      case (m_size)
         2'b00:   ;
         2'b01:   if (lane[0]) bad = 1'b1;
         2'b10:   if (lane != 2'b00) bad = 1'b1;
         default: bad = 1'b1;
      endcase
      if (offset[31:ADDR_W+2] != '0) bad = 1'b1;
   end

   // Read data is shifted down to bit 0 and captured in the acceptance cycle.
   assign rd_shift = mem[word_idx] >> {lane, 3'b000};

   always_comb begin
      rdata_d = rd_shift;
      case (m_size)
         2'b00:   rdata_d = m_unsigned ? {24'h0, rd_shift[7:0]}
                                       : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   rdata_d = m_unsigned ? {16'h0, rd_shift[15:0]}
                                       : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: rdata_d = rd_shift;
      endcase
   end

   always_comb begin
      wr_en   = accept & mWrite & ~bad;
      wr_idx  = word_idx;
      wr_be   = 4'hF;
      wr_data = write_data;
      case (m_size)
         2'b00: begin
            wr_be   = 4'b0001 << lane;
            wr_data = {4{write_data[7:0]}};
         end
         2'b01: begin
            wr_be   = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{write_data[15:0]}};
         end
         default: ;
      endcase
`ifdef DMEM_INIT_CLEAR_EN
      if (state_q == CLEAR) begin
         wr_en   = 1'b1;
         wr_idx  = clr_idx_q;
         wr_be   = 4'hF;
         wr_data = 32'h0;
      end
`endif
   end

   always_comb begin
      state_d = state_q;
`ifdef DMEM_INIT_CLEAR_EN
      clr_idx_d = clr_idx_q;
`endif
      case (state_q)
         CLEAR: begin
`ifdef DMEM_INIT_CLEAR_EN
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == '1) state_d = RUN;
`else
            state_d = RUN;
`endif
         end
         RUN:     state_d = RUN;
         default: state_d = RST_STATE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RST_STATE;
         ready_q  <= 1'b0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
`ifdef DMEM_INIT_CLEAR_EN
         clr_idx_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ready_q  <= (state_d == RUN);
         rvalid_q <= rd_ok;
         err_q    <= accept & bad;
         if (rd_ok) rdata_q <= rdata_d;
`ifdef DMEM_INIT_CLEAR_EN
         clr_idx_q <= clr_idx_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_be[0]) mem[wr_idx][7:0]   <= wr_data[7:0];
         if (wr_be[1]) mem[wr_idx][15:8]  <= wr_data[15:8];
         if (wr_be[2]) mem[wr_idx][23:16] <= wr_data[23:16];
         if (wr_be[3]) mem[wr_idx][31:24] <= wr_data[31:24];
      end
   end

   assign m_ready  = ready_q;
   assign m_rvalid = rvalid_q;
   assign m_err    = err_q;
   assign m_rdata  = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl
module tb_data_mem_ctrl;

`ifdef DMEM_INIT_CLEAR_EN
   localparam int AW        = 4;
   localparam int READY_LAT = 2**AW;
`else
   localparam int AW        = 10;
   localparam int READY_LAT = 1;
`endif
   localparam logic [31:0] OOR_ADDR = 32'(4 * (2**AW));
   localparam logic [31:0] B2B_ADDR = (AW > 4) ? 32'h40 : 32'h38;

   localparam logic [1:0] K_NONE = 2'd0;
   localparam logic [1:0] K_READ = 2'd1;
   localparam logic [1:0] K_ERR  = 2'd2;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mRead = 1'b0, mWrite = 1'b0;
   logic [1:0]  m_size = 2'b10;
   logic        m_unsigned = 1'b0;
   logic [31:0] addr_in = 32'h0, write_data = 32'h0;
   logic        m_ready, m_rvalid, m_err;
   logic [31:0] m_rdata;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] last_rdata = 32'h0;

   data_mem_ctrl #(.ADDR_W(AW), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst(rst), .mRead(mRead), .mWrite(mWrite), .m_size(m_size),
      .m_unsigned(m_unsigned), .addr_in(addr_in), .write_data(write_data),
      .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("rvalid", 32'(m_rvalid), 32'(e.kind == K_READ));
         chk("err", 32'(m_err), 32'(e.kind == K_ERR));
         if (e.kind == K_READ) begin
            chk("rdata", m_rdata, e.data);
            last_rdata = e.data;
         end else begin
            chk("hold_rdata", m_rdata, last_rdata);
         end
      end else begin
         chk("idle_rvalid", 32'(m_rvalid), 32'h0);
         chk("idle_err", 32'(m_err), 32'h0);
         chk("idle_rdata", m_rdata, last_rdata);
      end
   end

   task automatic req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] kind, input logic [31:0] ed);
      exp_t e;
      logic rdy;
      @(negedge clk);
      mRead = rd; mWrite = wr; m_size = sz; m_unsigned = uns;
      addr_in = a; write_data = wd;
      rdy = m_ready;
      chk("req_ready", 32'(rdy), 32'h1);
      @(posedge clk);
      if (rdy) begin
         e.kind = kind;
         e.data = ed;
         sb.push_back(e);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      mRead = 1'b0; mWrite = 1'b0;
   endtask

   task automatic wait_ready();
      int cnt;
      cnt = 0;
      mRead = 1'b1; mWrite = 1'b0; m_size = SZ_W; addr_in = 32'h4;
      while (cnt < 5000) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
         if (m_ready) break;
      end
      mRead = 1'b0;
      chk("ready_latency", 32'(cnt), 32'(READY_LAT));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst = 1'b0;
      #3;
      chk("rst_ready", 32'(m_ready), 32'h0);
      chk("rst_rvalid", 32'(m_rvalid), 32'h0);
      chk("rst_err", 32'(m_err), 32'h0);
      chk("rst_rdata", m_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      wait_ready();

`ifdef DMEM_INIT_CLEAR_EN
      req(1, 0, SZ_W, 0, 32'h04, 32'h0, K_READ, 32'h0);
      req(1, 0, SZ_W, 0, 32'h3C, 32'h0, K_READ, 32'h0);
`endif
      // word write/read
      req(0, 1, SZ_W, 0, 32'h10, 32'h12345678, K_NONE, 32'h0);
      req(1, 0, SZ_W, 1, 32'h10, 32'h0,        K_READ, 32'h12345678);
      idle();

      // sub-word accesses
      req(0, 1, SZ_W, 0, 32'h20, 32'hAABBCCDD, K_NONE, 32'h0);
      req(1, 0, SZ_B, 0, 32'h23, 32'h0,        K_READ, 32'hFFFFFFAA);
      req(1, 0, SZ_H, 1, 32'h22, 32'h0,        K_READ, 32'h0000AABB);
      req(1, 0, SZ_H, 0, 32'h22, 32'h0,        K_READ, 32'hFFFFAABB);
      req(0, 1, SZ_B, 0, 32'h21, 32'hFFFFFF11, K_NONE, 32'h0);
      req(1, 0, SZ_W, 0, 32'h20, 32'h0,        K_READ, 32'hAABB11DD);
      req(1, 0, SZ_B, 1, 32'h20, 32'h0,        K_READ, 32'h000000DD);
      idle();

      // rejected requests leave RAM untouched
      req(0, 1, SZ_W, 0, 32'h00, 32'h01020304, K_NONE, 32'h0);
      req(1, 0, SZ_W, 0, 32'h22, 32'h0,        K_ERR,  32'h0);
      req(0, 1, SZ_H, 0, 32'h21, 32'h00005555, K_ERR,  32'h0);
      req(1, 1, SZ_W, 0, 32'h20, 32'hFFFFFFFF, K_ERR,  32'h0);
      req(1, 0, SZ_X, 0, 32'h20, 32'h0,        K_ERR,  32'h0);
      req(0, 1, SZ_W, 0, OOR_ADDR, 32'hDEADBEEF, K_ERR, 32'h0);
      req(1, 0, SZ_W, 0, OOR_ADDR, 32'h0,      K_ERR,  32'h0);
      req(1, 0, SZ_W, 0, 32'h20, 32'h0,        K_READ, 32'hAABB11DD);
      req(1, 0, SZ_W, 0, 32'h00, 32'h0,        K_READ, 32'h01020304);
      idle();

      // back-to-back: write then immediate read, then 8 consecutive reads
      req(0, 1, SZ_W, 0, B2B_ADDR, 32'hCAFEF00D, K_NONE, 32'h0);
      req(1, 0, SZ_W, 0, B2B_ADDR, 32'h0,        K_READ, 32'hCAFEF00D);
      req(1, 0, SZ_W, 0, 32'h10,   32'h0,        K_READ, 32'h12345678);
      req(1, 0, SZ_W, 0, 32'h20,   32'h0,        K_READ, 32'hAABB11DD);
      req(1, 0, SZ_W, 0, 32'h00,   32'h0,        K_READ, 32'h01020304);
      req(1, 0, SZ_W, 0, B2B_ADDR, 32'h0,        K_READ, 32'hCAFEF00D);
      req(1, 0, SZ_B, 1, 32'h21,   32'h0,        K_READ, 32'h00000011);
      req(1, 0, SZ_H, 0, 32'h20,   32'h0,        K_READ, 32'h000011DD);
      req(1, 0, SZ_B, 1, 32'h23,   32'h0,        K_READ, 32'h000000AA);
      req(1, 0, SZ_B, 0, B2B_ADDR, 32'h0,        K_READ, 32'h0000000D);
      req(0, 1, SZ_H, 0, 32'h22,   32'hFFFF8001, K_NONE, 32'h0);
      req(1, 0, SZ_H, 0, 32'h22,   32'h0,        K_READ, 32'hFFFF8001);
      req(1, 0, SZ_W, 0, 32'h20,   32'h0,        K_READ, 32'h800111DD);
      idle();

      // reset during a read's response cycle
      @(negedge clk);
      mRead = 1'b1; mWrite = 1'b0; m_size = SZ_W; m_unsigned = 1'b0; addr_in = 32'h10;
      @(posedge clk);
      #1 mRead = 1'b0;
      #1 rst = 1'b0;
      last_rdata = 32'h0;
      #1;
      chk("midrst_rvalid", 32'(m_rvalid), 32'h0);
      chk("midrst_ready", 32'(m_ready), 32'h0);
      chk("midrst_err", 32'(m_err), 32'h0);
      chk("midrst_rdata", m_rdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      wait_ready();
`ifdef DMEM_INIT_CLEAR_EN
      req(1, 0, SZ_W, 0, 32'h10, 32'h0, K_READ, 32'h0);
`else
      req(1, 0, SZ_W, 0, 32'h10, 32'h0, K_READ, 32'h12345678);
`endif
      idle();
      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
